// File: rtl/wb_jtag_mailbox.sv
// Wishbone mailbox with TX/RX word FIFOs; ack one cycle after strobe, FIFO effects visible on the ack cycle.
// Full TX drops writes (sticky overflow), empty RX reads return 0 (sticky underflow); local side is valid/ready.

module mb_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_wdat,
  output logic [DW-1:0] o_rdat,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!i_reset || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage is not reset; the empty gate keeps stale words off the output.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_wdat;
  end

  assign o_rdat  = o_empty ? '0 : r_mem[r_rd];
  assign o_count = r_cnt;
endmodule

module wb_jtag_mailbox #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int S_Aw  = 7,
  parameter int SELw  = 4,
  parameter int TAGw  = 3,
  parameter int SW    = 32,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   s_dat_i,
  input  logic [SELw-1:0] s_sel_i,
  input  logic [S_Aw-1:0] s_addr_i,
  input  logic [TAGw-1:0] s_cti_i,
  input  logic            s_stb_i,
  input  logic            s_cyc_i,
  input  logic            s_we_i,
  output logic [DW-1:0]   s_dat_o,
  output logic            s_ack_o,
  output logic [DW-1:0]   tx_data_o,
  output logic            tx_valid_o,
  input  logic            tx_ready_i,
  input  logic [DW-1:0]   rx_data_i,
  input  logic            rx_valid_i,
  output logic            rx_ready_o,
  output logic [SW-1:0]   status_o
);
  typedef enum logic {ST_IDLE, ST_ACK} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_ack;
  logic [DW-1:0] r_dat;
  logic          r_tx_ovf;
  logic          r_rx_unf;

  logic          w_acc;
  logic [1:0]    w_a;
  logic          w_tx_push;
  logic          w_rx_pop;
  logic          w_ctrl;
  logic          w_tx_flush;
  logic          w_rx_flush;
  logic          w_clr;
  logic          w_tx_pop;
  logic          w_rx_push;
  logic [DW-1:0] w_rx_dat;
  logic [CW-1:0] w_tx_cnt;
  logic [CW-1:0] w_rx_cnt;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic [SW-1:0] w_status;
  logic [DW-1:0] w_rd_dat;
  logic          w_unused_ok;

  assign w_unused_ok = ^{s_sel_i, s_cti_i, s_addr_i[S_Aw-1:2]};

  // An access is performed only on the IDLE edge; strobes during ACK are ignored.
  assign w_acc      = (r_state == ST_IDLE) & s_stb_i & s_cyc_i;
  assign w_a        = s_addr_i[1:0];
  assign w_tx_push  = w_acc & s_we_i & (w_a == 2'd0);
  assign w_rx_pop   = w_acc & ~s_we_i & (w_a == 2'd0);
  assign w_ctrl     = w_acc & s_we_i & (w_a == 2'd2);
  assign w_tx_flush = w_ctrl & s_dat_i[0];
  assign w_rx_flush = w_ctrl & s_dat_i[1];
  assign w_clr      = w_ctrl & s_dat_i[2];
  assign w_tx_pop   = tx_ready_i & tx_valid_o;
  assign w_rx_push  = rx_valid_i & rx_ready_o;

  mb_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx (
    .clk     (clk),
    .i_reset (reset),
    .i_flush (w_tx_flush),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_wdat  (s_dat_i),
    .o_rdat  (tx_data_o),
    .o_count (w_tx_cnt),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  mb_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx (
    .clk     (clk),
    .i_reset (reset),
    .i_flush (w_rx_flush),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_wdat  (rx_data_i),
    .o_rdat  (w_rx_dat),
    .o_count (w_rx_cnt),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  assign tx_valid_o = ~w_tx_empty;
  assign rx_ready_o = ~w_rx_full;

  always_comb begin
    w_status        = '0;
    w_status[0]     = w_tx_full;
    w_status[1]     = w_tx_empty;
    w_status[2]     = w_rx_full;
    w_status[3]     = w_rx_empty;
    w_status[4]     = r_tx_ovf;
    w_status[5]     = r_rx_unf;
    w_status[15:8]  = 8'(w_tx_cnt);
    w_status[23:16] = 8'(w_rx_cnt);
  end
  assign status_o = w_status;

  always_comb begin
    w_rd_dat = '0;
    case (w_a)
      2'd0:    w_rd_dat = w_rx_dat;
      2'd1:    w_rd_dat = DW'(w_status);
      default: w_rd_dat = '0;
    endcase
  end

  // Clear wins over a set landing on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_tx_ovf <= 1'b0;
      r_rx_unf <= 1'b0;
      r_dat    <= '0;
    end else begin
      r_tx_ovf <= w_clr ? 1'b0 : (r_tx_ovf | (w_tx_push & w_tx_full));
      r_rx_unf <= w_clr ? 1'b0 : (r_rx_unf | (w_rx_pop & w_rx_empty));
      if (w_acc) r_dat <= s_we_i ? '0 : w_rd_dat;
    end
  end
  assign s_dat_o = r_dat;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (s_stb_i && s_cyc_i) w_state_nxt = ST_ACK;
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ack = 1'b0;
    if (r_state == ST_ACK) w_ack = 1'b1;
  end
  assign s_ack_o = w_ack;
endmodule
